// File: rtl/dmem_bus_bridge.sv
// rtl/dmem_bus_bridge.sv - core data-memory to external bus bridge (optional timeout: DMEM_BRIDGE_TIMEOUT_EN)
module dmem_bus_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_CNT_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_r,
    input  logic [3:0]            mem_w,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_dw,
    output logic [31:0]           mem_dr,
    output logic                  stall,
    output logic                  fault,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [3:0]            bus_be,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [31:0]           bus_wdata,
    input  logic                  bus_ready,
    input  logic [31:0]           bus_rdata,
    input  logic                  bus_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t     state;
    logic [1:0] lane;
    logic       req_wr;
    logic       req_any;
    logic       is_word;
    logic       is_half;
    logic       misaligned;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    logic [TO_CNT_WIDTH-1:0] to_cnt;
    logic [TO_CNT_WIDTH-1:0] to_cnt_next;
    logic                    to_expire;

    // Count the wait cycle being spent now; abort when it reaches the limit
    always_comb begin
        to_cnt_next = to_cnt + TO_CNT_WIDTH'(1);
        to_expire   = (to_cnt_next == TO_CNT_WIDTH'(TIMEOUT_CYCLES));
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^(TO_CNT_WIDTH'(TIMEOUT_CYCLES));
`endif

    // Decode request kind, access size and alignment; a write overrides a read
    always_comb begin
        req_wr     = |mem_w;
        req_any    = req_wr | mem_r;
        is_word    = req_wr ? (mem_w[3] | mem_w[2]) : 1'b1;
        is_half    = req_wr & ~mem_w[3] & ~mem_w[2] & mem_w[1];
        misaligned = (is_word & (|mem_addr[1:0])) | (is_half & mem_addr[0]);
    end

    // Hold the core while a request is waiting to launch or the bus is busy;
    // reset releases the core immediately even if a request is still presented
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = req_any;
            ACCESS:  stall = 1'b1;
            default: stall = 1'b0;
        endcase
        stall = stall & rst_n;
    end

    // Bridge sequencer with registered bus-side outputs, read data and fault pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lane      <= 2'b00;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= 4'b0000;
            bus_addr  <= '0;
            bus_wdata <= 32'h0;
            mem_dr    <= 32'h0;
            fault     <= 1'b0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            fault <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        if (misaligned) begin
                            // Never touches the bus; report and let the core move on
                            state  <= FAULT;
                            fault  <= 1'b1;
                            mem_dr <= 32'h0;
                        end else begin
                            state     <= ACCESS;
                            bus_req   <= 1'b1;
                            bus_we    <= req_wr;
                            bus_be    <= req_wr ? 4'(mem_w << mem_addr[1:0]) : 4'b0000;
                            bus_addr  <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
                            bus_wdata <= req_wr ? (mem_dw << {mem_addr[1:0], 3'b000}) : 32'h0;
                            lane      <= mem_addr[1:0];
`ifdef DMEM_BRIDGE_TIMEOUT_EN
                            to_cnt    <= '0;
`endif
                        end
                    end
                end
                ACCESS: begin
                    if (bus_ready) begin
                        // bus_ready beats a same-cycle timeout
                        bus_req <= 1'b0;
                        if (bus_err) begin
                            state  <= FAULT;
                            fault  <= 1'b1;
                            mem_dr <= 32'h0;
                        end else begin
                            state <= DONE;
                            if (!bus_we) begin
                                mem_dr <= bus_rdata >> {lane, 3'b000};
                            end
                        end
                    end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
                    else if (to_expire) begin
                        state   <= FAULT;
                        bus_req <= 1'b0;
                        fault   <= 1'b1;
                        mem_dr  <= 32'h0;
                    end else begin
                        to_cnt <= to_cnt_next;
                    end
`endif
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb/tb_dmem_bus_bridge.sv - directed self-checking bench for dmem_bus_bridge
module tb_dmem_bus_bridge;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    localparam int TO_LIMIT = 4;
`else
    localparam int TO_LIMIT = 255;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_r;
    logic [3:0]  mem_w;
    logic [31:0] mem_addr;
    logic [31:0] mem_dw;
    logic [31:0] mem_dr;
    logic        stall;
    logic        fault;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;

    logic        seen_req;
    logic        seen_we;
    logic [3:0]  seen_be;
    logic [31:0] seen_addr;
    logic [31:0] seen_wdata;
    logic        unstable;
    logic        fault_early;
    int          stalls;
    logic        hung;

    dmem_bus_bridge #(
        .ADDR_WIDTH    (32),
        .TIMEOUT_CYCLES(TO_LIMIT),
        .TO_CNT_WIDTH  (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem_r    (mem_r),
        .mem_w    (mem_w),
        .mem_addr (mem_addr),
        .mem_dw   (mem_dw),
        .mem_dr   (mem_dr),
        .stall    (stall),
        .fault    (fault),
        .bus_req  (bus_req),
        .bus_we   (bus_we),
        .bus_be   (bus_be),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_ready(bus_ready),
        .bus_rdata(bus_rdata),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_req(input logic r, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        mem_r    = r;
        mem_w    = w;
        mem_addr = a;
        mem_dw   = d;
    endtask

    task automatic end_req();
        @(posedge clk);
        #1;
        mem_r = 1'b0;
        mem_w = 4'b0000;
    endtask

    // Sample each cycle at negedge until stall drops; answer the bus after 'waits' ACCESS cycles
    task automatic do_access(input int waits, input logic err, input logic [31:0] rdata,
                             input int maxc, output int n_stall, output logic is_hung);
        int acc;
        acc         = 0;
        n_stall     = 0;
        is_hung     = 1'b1;
        seen_req    = 1'b0;
        unstable    = 1'b0;
        fault_early = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!stall) begin
                is_hung = 1'b0;
                break;
            end
            n_stall++;
            if (fault) fault_early = 1'b1;
            if (bus_req) begin
                if (!seen_req) begin
                    seen_we    = bus_we;
                    seen_be    = bus_be;
                    seen_addr  = bus_addr;
                    seen_wdata = bus_wdata;
                end else if (bus_we !== seen_we || bus_be !== seen_be ||
                             bus_addr !== seen_addr || bus_wdata !== seen_wdata) begin
                    unstable = 1'b1;
                end
                seen_req = 1'b1;
                if (acc == waits) begin
                    bus_ready = 1'b1;
                    bus_err   = err;
                    bus_rdata = rdata;
                end
                acc++;
            end
        end
        bus_ready = 1'b0;
        bus_err   = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_r     = 1'b0;
        mem_w     = 4'b0000;
        mem_addr  = 32'h0;
        mem_dw    = 32'h0;
        bus_ready = 1'b0;
        bus_rdata = 32'h0;
        bus_err   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_req", {31'b0, bus_req}, 32'h0);
        check("rst_bus_we", {31'b0, bus_we}, 32'h0);
        check("rst_bus_be", {28'b0, bus_be}, 32'h0);
        check("rst_bus_addr", bus_addr, 32'h0);
        check("rst_bus_wdata", bus_wdata, 32'h0);
        check("rst_mem_dr", mem_dr, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        rst_n = 1'b1;

        // 1: word read, immediate ready
        start_req(1'b1, 4'b0000, 32'h0000_1000, 32'h0);
        do_access(0, 1'b0, 32'hDEAD_BEEF, 50, stalls, hung);
        check("t1_hung", {31'b0, hung}, 32'h0);
        check("t1_stalls", stalls, 32'd2);
        check("t1_addr", seen_addr, 32'h0000_1000);
        check("t1_be", {28'b0, seen_be}, 32'h0);
        check("t1_we", {31'b0, seen_we}, 32'h0);
        check("t1_mem_dr", mem_dr, 32'hDEAD_BEEF);
        check("t1_req_done", {31'b0, bus_req}, 32'h0);
        check("t1_fault", {31'b0, fault | fault_early}, 32'h0);
        end_req();

        // 2: byte write at lane 3 with 3 wait cycles
        start_req(1'b0, 4'b0001, 32'h0000_2003, 32'h0000_00AB);
        do_access(3, 1'b0, 32'hFFFF_FFFF, 50, stalls, hung);
        check("t2_stalls", stalls, 32'd5);
        check("t2_be", {28'b0, seen_be}, 32'h8);
        check("t2_wdata", seen_wdata, 32'hAB00_0000);
        check("t2_addr", seen_addr, 32'h0000_2000);
        check("t2_we", {31'b0, seen_we}, 32'h1);
        check("t2_stable", {31'b0, unstable}, 32'h0);
        check("t2_mem_dr_hold", mem_dr, 32'hDEAD_BEEF);
        end_req();

        // halfword write at lane 2
        start_req(1'b0, 4'b0011, 32'h0000_5002, 32'h0000_BEEF);
        do_access(0, 1'b0, 32'h0, 50, stalls, hung);
        check("hw_stalls", stalls, 32'd2);
        check("hw_be", {28'b0, seen_be}, 32'hC);
        check("hw_wdata", seen_wdata, 32'hBEEF_0000);
        end_req();

        // word write with read also asserted: the write wins
        start_req(1'b1, 4'b1111, 32'h0000_6000, 32'h1234_5678);
        do_access(0, 1'b0, 32'h5555_5555, 50, stalls, hung);
        check("ww_we", {31'b0, seen_we}, 32'h1);
        check("ww_be", {28'b0, seen_be}, 32'hF);
        check("ww_wdata", seen_wdata, 32'h1234_5678);
        check("ww_mem_dr_hold", mem_dr, 32'hDEAD_BEEF);
        end_req();

        // 3: misaligned halfword write, then misaligned word read
        start_req(1'b0, 4'b0011, 32'h0000_3001, 32'h0000_1111);
        do_access(0, 1'b0, 32'h0, 50, stalls, hung);
        check("t3a_stalls", stalls, 32'd1);
        check("t3a_no_req", {31'b0, seen_req}, 32'h0);
        check("t3a_fault", {31'b0, fault}, 32'h1);
        check("t3a_mem_dr", mem_dr, 32'h0);
        end_req();
        @(negedge clk);
        check("t3a_fault_end", {31'b0, fault}, 32'h0);
        start_req(1'b1, 4'b0000, 32'h0000_3002, 32'h0);
        do_access(0, 1'b0, 32'h0, 50, stalls, hung);
        check("t3b_stalls", stalls, 32'd1);
        check("t3b_no_req", {31'b0, seen_req}, 32'h0);
        check("t3b_fault", {31'b0, fault}, 32'h1);
        end_req();
        @(negedge clk);
        check("t3b_fault_end", {31'b0, fault}, 32'h0);

        // 4: bus error on a read, then a normal read with one wait
        start_req(1'b1, 4'b0000, 32'h0000_4000, 32'h0);
        do_access(0, 1'b0, 32'hCAFE_0001, 50, stalls, hung);
        check("t4_pre_dr", mem_dr, 32'hCAFE_0001);
        end_req();
        start_req(1'b1, 4'b0000, 32'h0000_4004, 32'h0);
        do_access(0, 1'b1, 32'h1234_5678, 50, stalls, hung);
        check("t4_err_stalls", stalls, 32'd2);
        check("t4_err_fault", {31'b0, fault}, 32'h1);
        check("t4_err_dr", mem_dr, 32'h0);
        end_req();
        start_req(1'b1, 4'b0000, 32'h0000_4008, 32'h0);
        do_access(1, 1'b0, 32'hCAFE_F00D, 50, stalls, hung);
        check("t4_next_stalls", stalls, 32'd3);
        check("t4_next_dr", mem_dr, 32'hCAFE_F00D);
        check("t4_next_fault", {31'b0, fault | fault_early}, 32'h0);
        end_req();

        // 5: reset during ACCESS
        start_req(1'b1, 4'b0000, 32'h0000_7000, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("t5_in_access", {31'b0, bus_req}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_req", {31'b0, bus_req}, 32'h0);
        check("t5_rst_stall", {31'b0, stall}, 32'h0);
        check("t5_rst_dr", mem_dr, 32'h0);
        mem_r = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_after_req", {31'b0, bus_req}, 32'h0);
        start_req(1'b1, 4'b0000, 32'h0000_0000, 32'h0);
        do_access(0, 1'b0, 32'h00C0_FFEE, 50, stalls, hung);
        check("t5_stalls", stalls, 32'd2);
        check("t5_dr", mem_dr, 32'h00C0_FFEE);
        end_req();

        // 6: bus never answers
        start_req(1'b1, 4'b0000, 32'h0000_8000, 32'h0);
`ifdef DMEM_BRIDGE_TIMEOUT_EN
        do_access(1000, 1'b0, 32'h0, 50, stalls, hung);
        check("t6_hung", {31'b0, hung}, 32'h0);
        check("t6_stalls", stalls, 32'd5);
        check("t6_fault", {31'b0, fault}, 32'h1);
        check("t6_req_low", {31'b0, bus_req}, 32'h0);
        check("t6_dr", mem_dr, 32'h0);
        bus_ready = 1'b1;
        bus_rdata = 32'h7777_7777;
        end_req();
        @(negedge clk);
        bus_ready = 1'b0;
        check("t6_late_req", {31'b0, bus_req}, 32'h0);
        check("t6_late_dr", mem_dr, 32'h0);
        check("t6_late_fault", {31'b0, fault}, 32'h0);
`else
        do_access(1000, 1'b0, 32'h0, 120, stalls, hung);
        check("t6_hung", {31'b0, hung}, 32'h1);
        check("t6_stalls", stalls, 32'd120);
        check("t6_still_req", {31'b0, bus_req}, 32'h1);
        check("t6_no_fault", {31'b0, fault | fault_early}, 32'h0);
        rst_n = 1'b0;
        mem_r = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
